// File: rtl/mem_access_controller.sv
// MEM-stage data-memory sequencer: turns load/store requests into 16-bit
// word cycles, splitting 32-bit accesses into low word then high word.
module mem_access_controller (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_read,
    input  logic        i_req_write,
    input  logic        i_req_double,
    input  logic [15:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic [15:0] i_mem_read_data,
    output logic [15:0] o_mem_address,
    output logic [15:0] o_mem_write_data,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_read_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        dbl_q, dbl_d;
    logic        wr_q, wr_d;
    logic [15:0] lo_q, lo_d;
    logic        req_any;

    assign req_any = i_req_read | i_req_write;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        dbl_d            = dbl_q;
        wr_d             = wr_q;
        lo_d             = lo_q;
        o_mem_address    = 16'h0000;
        o_mem_write_data = 16'h0000;
        o_mem_read       = 1'b0;
        o_mem_write      = 1'b0;
        o_stall          = 1'b0;
        o_done           = 1'b0;
        o_read_data      = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                o_stall = req_any;
                if (req_any) begin
                    // a store wins over a simultaneous load
                    addr_d  = i_address;
                    data_d  = i_write_data;
                    dbl_d   = i_req_double;
                    wr_d    = i_req_write;
                    state_d = S_ACC0;
                end
            end
            S_ACC0: begin
                o_stall          = 1'b1;
                o_mem_address    = addr_q;
                o_mem_write_data = data_q[15:0];
                o_mem_read       = ~wr_q;
                o_mem_write      = wr_q;
                state_d          = dbl_q ? S_ACC1 : S_DONE;
            end
            S_ACC1: begin
                o_stall          = 1'b1;
                o_mem_address    = addr_q + 16'd1;
                o_mem_write_data = data_q[31:16];
                o_mem_read       = ~wr_q;
                o_mem_write      = wr_q;
                // memory returns the ACC0 word one cycle after its strobe
                if (!wr_q) begin
                    lo_d = i_mem_read_data;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (!wr_q) begin
                    o_read_data = dbl_q ? {i_mem_read_data, lo_q}
                                        : {16'h0000, i_mem_read_data};
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_reset) begin
            o_mem_address    = 16'h0000;
            o_mem_write_data = 16'h0000;
            o_mem_read       = 1'b0;
            o_mem_write      = 1'b0;
            o_stall          = 1'b0;
            o_done           = 1'b0;
            o_read_data      = 32'h0000_0000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= 16'h0000;
            data_q  <= 32'h0000_0000;
            dbl_q   <= 1'b0;
            wr_q    <= 1'b0;
            lo_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dbl_q   <= dbl_d;
            wr_q    <= wr_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: transaction-level expected-trace model,
// registered memory responder, directed cases and random traffic.
module tb_mem_access_controller;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_read = 1'b0;
    logic        i_req_write = 1'b0;
    logic        i_req_double = 1'b0;
    logic [15:0] i_address = 16'h0000;
    logic [31:0] i_write_data = 32'h0;
    logic [15:0] i_mem_read_data = 16'h0000;
    logic [15:0] o_mem_address;
    logic [15:0] o_mem_write_data;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_read_data;

    always #5 clk = ~clk;

    mem_access_controller dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_req_read      (i_req_read),
        .i_req_write     (i_req_write),
        .i_req_double    (i_req_double),
        .i_address       (i_address),
        .i_write_data    (i_write_data),
        .i_mem_read_data (i_mem_read_data),
        .o_mem_address   (o_mem_address),
        .o_mem_write_data(o_mem_write_data),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_stall         (o_stall),
        .o_done          (o_done),
        .o_read_data     (o_read_data)
    );

    logic [15:0] env_mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    // registered data memory driven by the DUT strobes
    always @(posedge clk) begin
        if (o_mem_write) env_mem[o_mem_address] <= o_mem_write_data;
        if (o_mem_read) i_mem_read_data <= env_mem[o_mem_address];
    end

    typedef struct packed {
        logic        stall;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        done;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // expected per-cycle outputs of one accepted request
    task automatic build(input bit wr, input bit dbl,
                         input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        logic [15:0] a1;
        a1 = a + 16'd1;
        e = '0;
        e.stall = 1'b1;
        e.rd = !wr;
        e.wr = wr;
        e.addr = a;
        e.wdata = d[15:0];
        q.push_back(e);
        if (dbl) begin
            e.addr = a1;
            e.wdata = d[31:16];
            q.push_back(e);
        end
        e = '0;
        e.done = 1'b1;
        if (!wr) e.rdata = dbl ? {ref_mem[a1], ref_mem[a]}
                               : {16'h0000, ref_mem[a]};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        act = {o_stall, o_mem_read, o_mem_write, o_mem_address,
               o_mem_write_data, o_done, o_read_data};
        if (i_reset) begin
            e = '0;
        end else if (q.size() > 0) begin
            e = q[0];
        end else begin
            e = '0;
            e.stall = i_req_read | i_req_write;
        end
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL cycle t=%0t got st=%b rd=%b wr=%b a=%h wd=%h dn=%b rdat=%h want st=%b rd=%b wr=%b a=%h wd=%h dn=%b rdat=%h",
                     $time, act.stall, act.rd, act.wr, act.addr, act.wdata,
                     act.done, act.rdata, e.stall, e.rd, e.wr, e.addr,
                     e.wdata, e.done, e.rdata);
        end
        if (i_reset) begin
            q.delete();
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.wr) ref_mem[e.addr] = e.wdata;
        end else if (i_req_read | i_req_write) begin
            build(i_req_write, i_req_double, i_address, i_write_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic set_req(input bit r, input bit w, input bit dbl,
                           input logic [15:0] a, input logic [31:0] d);
        i_req_read = r;
        i_req_write = w;
        i_req_double = dbl;
        i_address = a;
        i_write_data = d;
    endtask

    int d1, d2, nwr, nrd;
    logic [31:0] rd1;
    logic [15:0] a0, w0, a1, w1;
    logic [7:0] sb;

    // watch a bounded window starting at cycle 0 of a request
    task automatic run(input int ncyc, input int hold);
        int ns;
        d1 = -1; d2 = -1; nwr = 0; nrd = 0; rd1 = 32'hdead_beef;
        a0 = 16'hxxxx; w0 = 16'hxxxx; a1 = 16'hxxxx; w1 = 16'hxxxx;
        sb = 8'h00; ns = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k < 8) sb[k] = o_stall;
            if (o_done) begin
                if (d1 < 0) begin
                    d1 = k;
                    rd1 = o_read_data;
                end else if (d2 < 0) begin
                    d2 = k;
                end
            end
            if (o_mem_write) nwr++;
            if (o_mem_read) nrd++;
            if (o_mem_read | o_mem_write) begin
                if (ns == 0) begin a0 = o_mem_address; w0 = o_mem_write_data; end
                if (ns == 1) begin a1 = o_mem_address; w1 = o_mem_write_data; end
                ns++;
            end
            tick();
            if (k + 1 >= hold) set_req(0, 0, 0, 16'h0, 32'h0);
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] orig;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        tick();
        tick();
        set_req(1, 0, 0, 16'h0033, 32'h0);
        @(negedge clk);
        lit("reset_stall", {31'h0, o_stall}, 32'h0);
        lit("reset_strobes", {30'h0, o_mem_read, o_mem_write}, 32'h0);
        tick();
        i_reset = 1'b0;
        set_req(0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);
        lit("post_reset_idle", {30'h0, o_stall, o_mem_read}, 32'h0);
        tick();
        tick();

        set_req(0, 1, 0, 16'h0010, 32'h0000_0A00);
        run(6, 1);
        lit("swr_done_cyc", d1, 2);
        lit("swr_nwr", nwr, 1);
        lit("swr_addr", {16'h0, a0}, 32'h0010);
        lit("swr_data", {16'h0, w0}, 32'h0A00);
        lit("swr_stall", {29'h0, sb[2:0]}, 32'h3);
        lit("swr_mem", {16'h0, env_mem[16'h0010]}, 32'h0A00);

        env_mem[16'h0020] <= 16'h1111;
        env_mem[16'h0021] <= 16'h2222;
        ref_mem[16'h0020] = 16'h1111;
        ref_mem[16'h0021] = 16'h2222;
        tick();
        set_req(1, 0, 1, 16'h0020, 32'h0);
        run(6, 1);
        lit("drd_done_cyc", d1, 3);
        lit("drd_data", rd1, 32'h2222_1111);
        lit("drd_nrd", nrd, 2);
        lit("drd_addrs", {a0, a1}, 32'h0020_0021);

        set_req(0, 1, 1, 16'hFFFF, 32'hBEEF_CAFE);
        run(6, 1);
        lit("wrap_done_cyc", d1, 3);
        lit("wrap_first", {a0, w0}, 32'hFFFF_CAFE);
        lit("wrap_second", {a1, w1}, 32'h0000_BEEF);
        lit("wrap_mem", {env_mem[16'hFFFF], env_mem[16'h0000]}, 32'hCAFE_BEEF);

        set_req(1, 1, 0, 16'h0005, 32'h0000_7777);
        run(5, 1);
        lit("rw_done_cyc", d1, 2);
        lit("rw_strobes", {nrd[15:0], nwr[15:0]}, 32'h0000_0001);
        lit("rw_rdata", rd1, 32'h0);

        orig = env_mem[16'h0101];
        set_req(0, 1, 1, 16'h0100, 32'h1234_5678);
        tick();
        set_req(0, 0, 0, 16'h0, 32'h0);
        tick();
        i_reset = 1'b1;
        @(negedge clk);
        lit("rst_acc1_strobe", {31'h0, o_mem_write}, 32'h0);
        tick();
        i_reset = 1'b0;
        run(4, 1);
        lit("rst_no_done", d1, 32'hFFFF_FFFF);
        lit("rst_mem_hi", {16'h0, env_mem[16'h0101]}, {16'h0, orig});
        lit("rst_mem_lo", {16'h0, env_mem[16'h0100]}, 32'h5678);
        set_req(1, 0, 0, 16'h0100, 32'h0);
        run(5, 1);
        lit("rst_then_rd_cyc", d1, 2);
        lit("rst_then_rd", rd1, 32'h0000_5678);

        set_req(1, 0, 0, 16'h0040, 32'h0);
        run(7, 7);
        lit("hold_first", d1, 2);
        lit("hold_second", d2, 5);
        for (int i = 0; i < 5; i++) tick();

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            i_reset = ($urandom_range(0, 99) < 2);
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                            : 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                set_req(0, 0, 1'($urandom), a, $urandom);
            end else begin
                set_req(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom);
            end
            tick();
        end
        i_reset = 1'b0;
        set_req(0, 0, 0, 16'h0, 32'h0);
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
